// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator control path.
// Holds the operator and state encodings, BCD nibble check and operator rotation.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERROR   = 3'd5
  } calc_state_t;

  function automatic logic bcd_nibble_valid(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

  // ADD -> SUB -> MUL -> DIV -> ADD; the 2-bit add wraps naturally
  function automatic op_t op_cycle(input op_t cur);
    logic [1:0] val;
    val = cur;
    return op_t'(val + 2'd1);
  endfunction

endpackage

// File: rtl/btn_release_detect.sv
// Falling-edge (release) detector for one debounced button level.
// The pulse is combinational from the stored previous sample and the live level.
module btn_release_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_r;

  // Previous-sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level;
    end
  end

  assign pulse = prev_r & ~level;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand entry, operator selection, ALU launch and display mux.
// All state lives in *_r registers; next values are computed in one combinational block.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_dec,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_op,
  input  logic             btn_clear,
  input  logic             alu_done,
  input  logic             alu_err,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_start,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op,
  output logic             mode_dec,
  output logic [WIDTH-1:0] disp_value,
  output logic             err,
  output logic [2:0]       state_dbg
);

  localparam int CNT_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  calc_state_t      state_r, state_nxt_s;
  op_t              op_r, op_nxt_s;
  logic [WIDTH-1:0] operand_a_r, operand_a_nxt_s;
  logic [WIDTH-1:0] operand_b_r, operand_b_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             mode_dec_r, mode_dec_nxt_s;
  logic             err_r, err_nxt_s;
  logic             alu_start_r;
  logic             enter_ev_s, op_ev_s, clear_ev_s;
  logic             sw_bcd_s, sw_valid_s;

  btn_release_detect u_rel_enter (.clk(clk), .rst(rst), .level(btn_enter), .pulse(enter_ev_s));
  btn_release_detect u_rel_op    (.clk(clk), .rst(rst), .level(btn_op),    .pulse(op_ev_s));
  btn_release_detect u_rel_clear (.clk(clk), .rst(rst), .level(btn_clear), .pulse(clear_ev_s));

  // Switch word is acceptable in hex mode, or when every nibble is a BCD digit
  always_comb begin
    sw_bcd_s = 1'b1;
    for (int i = 0; i < WIDTH / 4; i++) begin
      sw_bcd_s = sw_bcd_s & bcd_nibble_valid(sw[4*i +: 4]);
    end
  end

  assign sw_valid_s = ~is_dec | sw_bcd_s;

  // Next-state and next-register computation
  always_comb begin
    state_nxt_s     = state_r;
    op_nxt_s        = op_r;
    operand_a_nxt_s = operand_a_r;
    operand_b_nxt_s = operand_b_r;
    result_nxt_s    = result_r;
    cnt_nxt_s       = cnt_r;
    mode_dec_nxt_s  = mode_dec_r;
    err_nxt_s       = err_r;
    if (clear_ev_s) begin
      state_nxt_s     = ST_ENTER_A;
      op_nxt_s        = OP_ADD;
      operand_a_nxt_s = '0;
      operand_b_nxt_s = '0;
      err_nxt_s       = 1'b0;
    end else begin
      case (state_r)
        ST_ENTER_A, ST_ENTER_B: begin
          if (op_ev_s) begin
            op_nxt_s = op_cycle(op_r);
          end else begin
            op_nxt_s = op_r;
          end
          if (enter_ev_s && sw_valid_s) begin
            err_nxt_s = 1'b0;
            if (state_r == ST_ENTER_A) begin
              operand_a_nxt_s = sw;
              state_nxt_s     = ST_ENTER_B;
            end else begin
              operand_b_nxt_s = sw;
              state_nxt_s     = ST_EXEC;
            end
          end else if (enter_ev_s) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
        end
        ST_EXEC: begin
          mode_dec_nxt_s = is_dec;
          cnt_nxt_s      = '0;
          state_nxt_s    = ST_WAIT;
        end
        ST_WAIT: begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          // A completion in the same cycle as the timeout takes precedence
          if (alu_done) begin
            result_nxt_s = alu_result;
            if (alu_err) begin
              state_nxt_s = ST_ERROR;
              err_nxt_s   = 1'b1;
            end else begin
              state_nxt_s = ST_SHOW;
            end
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_ERROR;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_SHOW: begin
          if (op_ev_s) begin
            op_nxt_s = op_cycle(op_r);
          end else begin
            op_nxt_s = op_r;
          end
          // Chain the previous result into A when the user continues
          if ((enter_ev_s && sw_valid_s) || op_ev_s) begin
            operand_a_nxt_s = result_r;
            state_nxt_s     = ST_ENTER_B;
          end else begin
            operand_a_nxt_s = operand_a_r;
          end
          if (enter_ev_s) begin
            err_nxt_s = ~sw_valid_s;
          end else begin
            err_nxt_s = err_r;
          end
        end
        ST_ERROR: begin
          if (enter_ev_s) begin
            state_nxt_s     = ST_ENTER_A;
            operand_a_nxt_s = '0;
            operand_b_nxt_s = '0;
            err_nxt_s       = 1'b0;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_ENTER_A;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_ENTER_A;
      op_r        <= OP_ADD;
      operand_a_r <= '0;
      operand_b_r <= '0;
      result_r    <= '0;
      cnt_r       <= '0;
      mode_dec_r  <= 1'b1;
      err_r       <= 1'b0;
      alu_start_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      op_r        <= op_nxt_s;
      operand_a_r <= operand_a_nxt_s;
      operand_b_r <= operand_b_nxt_s;
      result_r    <= result_nxt_s;
      cnt_r       <= cnt_nxt_s;
      mode_dec_r  <= mode_dec_nxt_s;
      err_r       <= err_nxt_s;
      alu_start_r <= (state_nxt_s == ST_EXEC);
    end
  end

  // Display mux; live switches are shown while no result is pending
  always_comb begin
    case (state_r)
      ST_SHOW:  disp_value = result_r;
      ST_ERROR: disp_value = '0;
      default:  disp_value = sw;
    endcase
  end

  assign alu_start = alu_start_r;
  assign operand_a = operand_a_r;
  assign operand_b = operand_b_r;
  assign op        = op_r;
  assign mode_dec  = mode_dec_r;
  assign err       = err_r;
  assign state_dbg = state_r;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level control FSM for the calculator. It turns button releases into operand capture, operator selection, ALU launch and result display. It drives the shared ALU through a start/done handshake and muxes the value shown on the display. It sits between the debounced button/switch inputs, the decimal/hex mode flag, the ALU and the 7-segment driver.

## Interface
- `WIDTH`, 16: operand, result and display width; must be a multiple of 4.
- `ALU_TIMEOUT`, 255: maximum number of cycles spent in WAIT before an error is forced; must be ≥ 2.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `is_dec` in 1: mode flag; 1 = decimal (BCD entry), 0 = hex.
- `sw` in WIDTH: operand entry switches.
- `btn_enter`, `btn_op`, `btn_clear` in 1 each: debounced, synchronized button levels.
- `alu_done` in 1: ALU completion strobe.
- `alu_err` in 1: ALU error; valid only while `alu_done` is high.
- `alu_result` in WIDTH: ALU result; valid only while `alu_done` is high.
- `alu_start` out 1: one-cycle launch pulse.
- `operand_a`, `operand_b` out WIDTH: operands presented to the ALU.
- `op` out 2: operator (ADD=0, SUB=1, MUL=2, DIV=3).
- `mode_dec` out 1: `is_dec` latched at launch; held constant for the ALU for the whole operation.
- `disp_value` out WIDTH: value to display.
- `err` out 1: error indicator.
- `state_dbg` out 3: current state encoding.

## Operation
- Button events occur on release only: an event fires when the previous sample was 1 and the current sample is 0. The previous-sample registers reset to 0.
- If `btn_clear` and `btn_enter` release in the same cycle, clear takes priority.
- **Clear (any state).** Go to ENTER_A. `operand_a` and `operand_b` go to 0, `op` goes to ADD, `err` goes to 0.
- **Entry validity.** In decimal mode, `sw` is invalid if any nibble is greater than 9. An enter with invalid `sw`:
  - is rejected: no capture, no state change;
  - sets `err`.
  - Any accepted enter clears `err`.
  - `is_dec` is evaluated at the press cycle.
- **States** (`state_dbg` encoding in brackets):
  - **ENTER_A [0].** `disp_value` = `sw` (live). An op release cycles `op` ADD→SUB→MUL→DIV→ADD. A valid enter captures `operand_a` <= `sw` and moves to ENTER_B.
  - **ENTER_B [1].** `disp_value` = `sw`. Op cycling is allowed. A valid enter captures `operand_b` <= `sw` and moves to EXEC.
  - **EXEC [2].** `alu_start` = 1 for exactly this cycle. `mode_dec` <= `is_dec`. Moves to WAIT. Button events are ignored.
  - **WAIT [3].** The timeout counter increments each cycle. If `alu_done` is high:
    - `result` <= `alu_result`;
    - go to ERROR if `alu_err`, otherwise SHOW.
    - Otherwise, when the counter reaches `ALU_TIMEOUT`-1, go to ERROR. If `alu_done` and timeout coincide, `alu_done` wins.
    - Enter and op events are ignored.
  - **SHOW [4].** `disp_value` = `result`. A valid enter does `operand_a` <= `result` (chaining) and moves to ENTER_B. An op release cycles `op` and moves to ENTER_B, also with `operand_a` <= `result`.
  - **ERROR [5].** `err` = 1, `disp_value` = 0. Enter or clear moves to ENTER_A with operands zeroed.
- `alu_done` is sampled only in WAIT. A late `alu_done` after a clear is ignored.
- **Reset values:**
  - state ENTER_A;
  - `operand_a`/`operand_b`/`result` = 0;
  - `op` = ADD;
  - `mode_dec` = 1;
  - `err` = 0;
  - `alu_start` = 0;
  - `disp_value` = `sw`.

## Timing
- Release detection is combinational from the prev register and the current input. A release first visible in cycle N updates state and registers at the end of cycle N.
- Enter accepted in ENTER_B at cycle N: EXEC and `alu_start`=1 in N+1; WAIT from N+2.
- `alu_done` in cycle M: SHOW or ERROR, `result` and `disp_value` valid from M+1.
- Timeout: with `alu_done` never asserted, ERROR is entered exactly `ALU_TIMEOUT` cycles after entering WAIT. The counter is cleared on entry to WAIT.
- Reset asserted mid-operation: all registers take their reset values at the next edge. `alu_start` is low in the following cycle.
- `disp_value`, `err` and `alu_start` are Moore outputs of registered state.

## Structure
- Shared package `calc_pkg` holds:
  - the `op_t` enum (2-bit);
  - the `calc_state_t` enum (3-bit, encodings as above);
  - the BCD-nibble-valid helper function.
- Sub-module `btn_release_detect` (`clk`, `rst`, `level` → `pulse`) is instantiated three times.

## Test plan
- **Hex add.** `is_dec`=0, `sw`=0x0012 enter, `sw`=0x0030 enter → `alu_start` pulse 1 cycle with A=0x0012, B=0x0030, `op`=ADD. `alu_done`+`result` 0x0042 → SHOW, `disp_value`=0x0042.
- **BCD reject.** `is_dec`=1, `sw`=0x001A enter → state stays ENTER_A, `err`=1. Then `sw`=0x0019 enter → `err`=0, ENTER_B.
- **Op cycling and chaining.** Op released 5 times → `op`=SUB. From SHOW with `result` 0x0007, enter → `operand_a`=0x0007, ENTER_B.
- **Timeout.** `ALU_TIMEOUT`=8, `alu_done` held 0 → ERROR exactly 8 cycles after WAIT entry, `err`=1, `disp_value`=0. `alu_done` on the 8th cycle instead → SHOW.
- **ALU error.** `alu_done`=1 with `alu_err`=1 → ERROR. Clear and enter released in the same cycle → ENTER_A, operands 0, `op`=ADD.
- **Reset mid-WAIT.** `rst` pulsed in WAIT → ENTER_A next cycle. A subsequent `alu_done` causes no state change.
